// File: rtl/pad_pkg.sv
// pad_pkg: shared definitions for the NES-style pad poller.
//   - pad_state_t : scan FSM state encoding
//   - BTN_*       : bit position of each button inside a pad's 8-bit field
//   - NES_*       : default timing for a 25 MHz clock (6 us phase, 60 Hz poll)
package pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } pad_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int BITS_PER_PAD   = 8;
  localparam int NES_CLK_DIV    = 150;
  localparam int NES_POLL_TICKS = 416667;

endpackage

// File: rtl/pad_poll_timer.sv
// pad_poll_timer: free-running poll counter plus a single scan-request flag.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   take - scan FSM is accepting the request this cycle (clears the flag)
//   req  - a scan is requested; held until taken, never counted twice
module pad_poll_timer
  import pad_pkg::*;
#(
  parameter int POLL_TICKS = NES_POLL_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  output logic req
);

  localparam int CNT_W = $clog2(POLL_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      req <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
      // A wrap coinciding with acceptance is the same request being serviced.
      if (take)                 req <= 1'b0;
      else if (cnt == CNT_LAST) req <= 1'b1;
    end
  end

endmodule

// File: rtl/pad_poller.sv
// pad_poller: polls NUM_PADS NES-style serial pads in parallel.
// Ports:
//   clk_25mhz  - sole clock
//   rst        - synchronous active-low reset
//   enable     - permits new scans to start (a running scan always finishes)
//   pad_ser_in - serial data per pad, buttons active-low
//   int_ack    - per-pad one-cycle clear of the pending interrupt
//   latch_out  - latch strobe shared by all pads
//   clk_out    - serial shift clock shared by all pads
//   pad_data   - active-high buttons, pad p in bits [8p+7:8p], bit k = serial bit k
//   pad_valid  - one-cycle pulse when pad_data updates
//   int_out    - per-pad pending interrupt (level)
//   int_any    - OR of int_out
module pad_poller
  import pad_pkg::*;
#(
  parameter int NUM_PADS   = 2,
  parameter int CLK_DIV    = NES_CLK_DIV,
  parameter int POLL_TICKS = NES_POLL_TICKS,
  parameter int IRQ_MODE   = 0
) (
  input  logic                           clk_25mhz,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_PADS-1:0]            pad_ser_in,
  input  logic [NUM_PADS-1:0]            int_ack,
  output logic                           latch_out,
  output logic                           clk_out,
  output logic [BITS_PER_PAD*NUM_PADS-1:0] pad_data,
  output logic                           pad_valid,
  output logic [NUM_PADS-1:0]            int_out,
  output logic                           int_any
);

  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(CLK_DIV - 1);

  pad_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_idx;
  logic req, take, capture, done;
  logic [BITS_PER_PAD*NUM_PADS-1:0] shreg;
  logic [NUM_PADS-1:0] evt, pending;

  pad_poll_timer #(.POLL_TICKS(POLL_TICKS)) u_timer (
    .clk  (clk_25mhz),
    .rst  (rst),
    .take (take),
    .req  (req)
  );

  // Mode 0 flags any change, mode 1 only buttons that went from released to pressed.
  function automatic logic pad_event(input logic [7:0] nw, input logic [7:0] old);
    if (IRQ_MODE == 1) return |(nw & ~old);
    else               return |(nw ^ old);
  endfunction

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [7:0] sh;
    always_ff @(posedge clk_25mhz) begin
      if (!rst)         sh <= '0;
      else if (capture) sh[bit_idx] <= ~pad_ser_in[p];
    end
    assign shreg[8*p +: 8] = sh;
    assign evt[p] = pad_event(sh, pad_data[8*p +: 8]);
  end

  always_comb begin
    state_nx  = state;
    latch_out = 1'b0;
    clk_out   = 1'b0;
    take      = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && enable) begin
          state_nx = ST_LATCH;
          take     = 1'b1;
        end
      end
      ST_LATCH: begin
        latch_out = 1'b1;
        if (cnt == LATCH_LAST) state_nx = ST_LOW;
      end
      ST_LOW: begin
        // Sample at the end of the low phase, when the pad output has settled.
        if (cnt == PHASE_LAST) begin
          capture  = 1'b1;
          state_nx = (bit_idx == 3'(BTN_RIGHT)) ? ST_DONE : ST_HIGH;
        end
      end
      ST_HIGH: begin
        clk_out = 1'b1;
        if (cnt == PHASE_LAST) state_nx = ST_LOW;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      pad_data  <= '0;
      pad_valid <= 1'b0;
      pending   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == ST_IDLE) cnt <= '0;
      else                                       cnt <= cnt + CNT_W'(1);
      if (take)                                      bit_idx <= '0;
      else if (state == ST_HIGH && state_nx == ST_LOW) bit_idx <= bit_idx + 3'd1;
      pad_valid <= done;
      if (done) pad_data <= shreg;
      // New events override a simultaneous acknowledge.
      pending <= (pending & ~int_ack) | (done ? evt : '0);
    end
  end

  assign int_out = pending;
  assign int_any = |pending;

endmodule

// File: tb/tb_pad_poller.sv
// tb_pad_poller: scoreboard bench for pad_poller (NUM_PADS=2, CLK_DIV=2,
// POLL_TICKS=100). Two instances share all inputs: dut0 with IRQ_MODE=0 and
// dut1 with IRQ_MODE=1. A behavioural pad model drives the serial lines.
module tb_pad_poller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pad_in;
  logic [1:0]  ack;
  logic        latch0, clk0, valid0, any0;
  logic        latch1, clk1, valid1, any1;
  logic [15:0] data0, data1;
  logic [1:0]  int0, int1;

  always #5 clk = ~clk;

  pad_poller #(.NUM_PADS(2), .CLK_DIV(2), .POLL_TICKS(100), .IRQ_MODE(0)) dut0 (
    .clk_25mhz(clk), .rst(rst), .enable(enable), .pad_ser_in(pad_in), .int_ack(ack),
    .latch_out(latch0), .clk_out(clk0), .pad_data(data0), .pad_valid(valid0),
    .int_out(int0), .int_any(any0));

  pad_poller #(.NUM_PADS(2), .CLK_DIV(2), .POLL_TICKS(100), .IRQ_MODE(1)) dut1 (
    .clk_25mhz(clk), .rst(rst), .enable(enable), .pad_ser_in(pad_in), .int_ack(ack),
    .latch_out(latch1), .clk_out(clk1), .pad_data(data1), .pad_valid(valid1),
    .int_out(int1), .int_any(any1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // cycle bookkeeping: rc()==0 right after the first rising edge with rst high
  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int rc();
    return cyc - base - 1;
  endfunction

  task automatic wait_rc(input int n);
    while (rc() < n) @(negedge clk);
  endtask

  // pad model: buttons pressed = 1; serial bit k presented after k clock pulses
  logic [7:0] btn0 = '0, btn1 = '0;
  logic [2:0] kidx = '0;
  assign pad_in = {~btn1[kidx], ~btn0[kidx]};

  // reference model and scoreboard
  typedef struct {
    logic [15:0] data;
    logic [1:0]  i0;
    logic [1:0]  i1;
    int          vrc;
  } exp_t;
  exp_t        q[$];
  logic [15:0] m_old   = '0;
  logic [1:0]  m_pend0 = '0;
  logic [1:0]  m_pend1 = '0;

  task automatic push_scan(input logic [7:0] b0, input logic [7:0] b1, input int vrc);
    logic [15:0] nw;
    exp_t e;
    btn0 = b0;
    btn1 = b1;
    nw = {b1, b0};
    for (int p = 0; p < 2; p++) begin
      if ((nw[8*p +: 8] ^ m_old[8*p +: 8]) != 8'h00)  m_pend0[p] = 1'b1;
      if ((nw[8*p +: 8] & ~m_old[8*p +: 8]) != 8'h00) m_pend1[p] = 1'b1;
    end
    m_old  = nw;
    e.data = nw;
    e.i0   = m_pend0;
    e.i1   = m_pend1;
    e.vrc  = vrc;
    q.push_back(e);
  endtask

  // monitor: latch/clock timing and scoreboard pop on pad_valid
  logic latch_prev = 1'b0, clk_prev = 1'b0;
  int   last_latch = -1;
  int   latch_len  = 0;
  int   pulses     = 0;
  exp_t ex;

  always @(negedge clk) begin
    if (latch0 && !latch_prev) begin
      last_latch <= rc();
      latch_len  <= 1;
      pulses     <= 0;
    end else if (latch0) begin
      latch_len <= latch_len + 1;
    end
    if (clk0 && !clk_prev) pulses <= pulses + 1;
    if (latch0)                kidx <= 3'd0;
    else if (clk_prev && !clk0) kidx <= kidx + 3'd1;
    latch_prev <= latch0;
    clk_prev   <= clk0;

    if (valid0) begin
      if (q.size() == 0) begin
        chk("sb_underflow", q.size(), 1);
      end else begin
        ex = q.pop_front();
        chk("valid_cycle", rc(), ex.vrc);
        chk("latch_rise", last_latch, ex.vrc - 35);
        chk("latch_len", latch_len, 4);
        chk("clk_pulses", pulses, 7);
        chk("valid1", valid1, 1'b1);
        chk("data0", data0, ex.data);
        chk("data1", data1, ex.data);
        chk("int_mode0", int0, ex.i0);
        chk("int_mode1", int1, ex.i1);
      end
    end
  end

  always @(posedge clk) begin
    if (cyc > 3000) begin
      $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    ack    = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_latch", latch0, 1'b0);
    chk("rst_clk", clk0, 1'b0);
    chk("rst_data", data0, 16'h0000);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_int0", int0, 2'b00);
    chk("rst_int1", int1, 2'b00);

    rst  = 1'b1;
    base = cyc;
    push_scan(8'h00, 8'h00, 135);

    // pad0 A+Start, pad1 Right
    wait_rc(150);
    push_scan(8'h09, 8'h80, 235);
    wait_rc(236);
    chk("any_mode0", any0, 1'b1);
    chk("any_mode1", any1, 1'b1);
    wait_rc(240);
    ack = 2'b11;
    @(negedge clk);
    ack = 2'b00;
    m_pend0 = '0;
    m_pend1 = '0;
    chk("ack_int0", int0, m_pend0);
    chk("ack_int1", int1, m_pend1);
    chk("ack_any0", any0, 1'b0);

    // release pad0: a change but not a press
    wait_rc(250);
    push_scan(8'h00, 8'h80, 335);
    wait_rc(340);
    ack = 2'b11;
    @(negedge clk);
    ack = 2'b00;
    m_pend0 = '0;
    m_pend1 = '0;

    // pad0 B pressed; ack[0] lands in the same cycle as the event
    wait_rc(350);
    push_scan(8'h02, 8'h80, 435);
    wait_rc(434);
    ack = 2'b01;
    @(negedge clk);
    ack = 2'b00;
    wait_rc(440);
    ack = 2'b01;
    @(negedge clk);
    ack = 2'b00;
    m_pend0[0] = 1'b0;
    m_pend1[0] = 1'b0;
    chk("lone_ack_int0", int0, m_pend0);
    chk("lone_ack_int1", int1, m_pend1);

    // release pad1, drop enable mid-scan
    wait_rc(450);
    push_scan(8'h02, 8'h00, 535);
    wait_rc(515);
    enable = 1'b0;
    wait_rc(649);
    chk("held_no_latch", last_latch, 500);
    wait_rc(650);
    enable = 1'b1;
    wait_rc(652);
    chk("held_latch_rise", last_latch, 651);

    // reset in the middle of the shift phase
    wait_rc(660);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_latch", latch0, 1'b0);
    chk("mid_rst_clk", clk0, 1'b0);
    chk("mid_rst_data", data0, 16'h0000);
    chk("mid_rst_int0", int0, 2'b00);
    chk("mid_rst_int1", int1, 2'b00);
    rst  = 1'b1;
    base = cyc;
    m_old   = '0;
    m_pend0 = '0;
    m_pend1 = '0;
    push_scan(8'h02, 8'h00, 135);
    wait_rc(140);
    chk("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
